// File: rtl/l2_req_arbiter_pkg.sv
// Package cache_def: shared width defaults, FSM/owner enums and the latched
// request struct for the L2 request arbiter.
package cache_def;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned LINE_W = 128;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RELEASE
   } arb_state_e;

   typedef enum logic {
      OWN_I,
      OWN_D
   } arb_owner_e;

   typedef struct packed {
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] data;
   } arb_req_t;

endpackage

// File: rtl/l2_req_arbiter_if.sv
// Request/response bundle between the two L1 miss paths, the arbiter and the
// downstream L2 port. slave = arbiter view, master = environment view.
interface l2_req_arbiter_if #(
   parameter int unsigned ADDR_W = cache_def::ADDR_W,
   parameter int unsigned LINE_W = cache_def::LINE_W
);
   logic              i_req_valid_i;
   logic              i_req_rw_i;
   logic [ADDR_W-1:0] i_req_addr_i;
   logic [LINE_W-1:0] i_req_data_i;
   logic [LINE_W-1:0] i_res_data_o;
   logic              i_res_ready_o;

   logic              d_req_valid_i;
   logic              d_req_rw_i;
   logic [ADDR_W-1:0] d_req_addr_i;
   logic [LINE_W-1:0] d_req_data_i;
   logic [LINE_W-1:0] d_res_data_o;
   logic              d_res_ready_o;

   logic              mem_req_valid_o;
   logic              mem_req_rw_o;
   logic [ADDR_W-1:0] mem_req_addr_o;
   logic [LINE_W-1:0] mem_req_data_o;
   logic              mem_res_ready_i;
   logic [LINE_W-1:0] mem_res_data_i;

   modport slave (
      input  i_req_valid_i, i_req_rw_i, i_req_addr_i, i_req_data_i,
      output i_res_data_o, i_res_ready_o,
      input  d_req_valid_i, d_req_rw_i, d_req_addr_i, d_req_data_i,
      output d_res_data_o, d_res_ready_o,
      output mem_req_valid_o, mem_req_rw_o, mem_req_addr_o, mem_req_data_o,
      input  mem_res_ready_i, mem_res_data_i
   );

   modport master (
      output i_req_valid_i, i_req_rw_i, i_req_addr_i, i_req_data_i,
      input  i_res_data_o, i_res_ready_o,
      output d_req_valid_i, d_req_rw_i, d_req_addr_i, d_req_data_i,
      input  d_res_data_o, d_res_ready_o,
      input  mem_req_valid_o, mem_req_rw_o, mem_req_addr_o, mem_req_data_o,
      output mem_res_ready_i, mem_res_data_i
   );

endinterface

// File: rtl/l2_req_arbiter_rr_picker.sv
// l2_rr_picker: combinational two-way round-robin winner selection.
// Holds no state; the caller owns rr_last and its update.
module l2_rr_picker
   import cache_def::*;
(
   input  logic       i_valid_i,
   input  logic       d_valid_i,
   input  arb_owner_e rr_last_i,
   output logic       grant_valid_o,
   output arb_owner_e winner_o
);

   // Lone requester wins; on a tie the port that did not win last goes.
   always_comb begin
      grant_valid_o = i_valid_i | d_valid_i;
      winner_o      = OWN_I;
      if (i_valid_i && d_valid_i) begin
         winner_o = (rr_last_i == OWN_I) ? OWN_D : OWN_I;
      end else if (d_valid_i) begin
         winner_o = OWN_D;
      end
   end

endmodule

// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: shares one downstream L2 request port between the I-cache
// and D-cache miss paths. Optional macro ARB_PERF_CNT_EN adds a saturating
// count of contended grants on conflict_cnt_o.
module l2_req_arbiter #(
   parameter int unsigned ADDR_W = cache_def::ADDR_W,
   parameter int unsigned LINE_W = cache_def::LINE_W
`ifdef ARB_PERF_CNT_EN
   ,
   parameter int unsigned CNT_W  = 32
`endif
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   l2_req_arbiter_if.slave      bus,
   output logic                 busy_o
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]     conflict_cnt_o
`endif
);
   import cache_def::*;

   arb_state_e        state_q;
   arb_owner_e        owner_q;
   arb_owner_e        rr_last_q;
   arb_req_t          req_q;
   arb_req_t          req_d;
   logic              mem_req_valid_q;

   logic              grant_valid;
   arb_owner_e        winner;
   logic              sel_rw;
   logic [ADDR_W-1:0] sel_addr;
   logic [LINE_W-1:0] sel_data;
   logic              res_fire;

   l2_rr_picker u_picker (
      .i_valid_i     (bus.i_req_valid_i),
      .d_valid_i     (bus.d_req_valid_i),
      .rr_last_i     (rr_last_q),
      .grant_valid_o (grant_valid),
      .winner_o      (winner)
   );

   // Steer the winning port's request fields into the latch input.
   always_comb begin
      sel_rw   = bus.i_req_rw_i;
      sel_addr = bus.i_req_addr_i;
      sel_data = bus.i_req_data_i;
      if (winner == OWN_D) begin
         sel_rw   = bus.d_req_rw_i;
         sel_addr = bus.d_req_addr_i;
         sel_data = bus.d_req_data_i;
      end
      req_d      = '0;
      req_d.rw   = sel_rw;
      req_d.addr = sel_addr;
      req_d.data = sel_data;
   end

   // Grant/hold/release FSM; all downstream request outputs are registered.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= IDLE;
         owner_q         <= OWN_I;
         rr_last_q       <= OWN_D;
         req_q           <= '0;
         mem_req_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_valid) begin
                  req_q           <= req_d;
                  owner_q         <= winner;
                  rr_last_q       <= winner;
                  mem_req_valid_q <= 1'b1;
                  state_q         <= BUSY;
               end
            end
            BUSY: begin
               if (bus.mem_res_ready_i) begin
                  mem_req_valid_q <= 1'b0;
                  state_q         <= RELEASE;
               end
            end
            RELEASE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign res_fire = (state_q == BUSY) && bus.mem_res_ready_i;

   // Route the response only to the owner; data is zero whenever ready is low.
   always_comb begin
      bus.i_res_ready_o = 1'b0;
      bus.d_res_ready_o = 1'b0;
      bus.i_res_data_o  = '0;
      bus.d_res_data_o  = '0;
      if (res_fire && owner_q == OWN_I) begin
         bus.i_res_ready_o = 1'b1;
         bus.i_res_data_o  = bus.mem_res_data_i;
      end
      if (res_fire && owner_q == OWN_D) begin
         bus.d_res_ready_o = 1'b1;
         bus.d_res_data_o  = bus.mem_res_data_i;
      end
   end

   assign bus.mem_req_valid_o = mem_req_valid_q;
   assign bus.mem_req_rw_o    = req_q.rw;
   assign bus.mem_req_addr_o  = req_q.addr;
   assign bus.mem_req_data_o  = req_q.data;
   assign busy_o              = (state_q != IDLE);

`ifdef ARB_PERF_CNT_EN
   logic [CNT_W-1:0] conflict_cnt_q;

   // Count IDLE grant cycles with both ports requesting, saturating at all-ones.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         conflict_cnt_q <= '0;
      end else if (state_q == IDLE && bus.i_req_valid_i && bus.d_req_valid_i &&
                   conflict_cnt_q != '1) begin
         conflict_cnt_q <= conflict_cnt_q + CNT_W'(1);
      end
   end

   assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed self-checking bench for l2_req_arbiter.
module tb_l2_req_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   logic busy;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] conflict_cnt;
`endif

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   l2_req_arbiter_if #(.ADDR_W(32), .LINE_W(128)) bus ();

   l2_req_arbiter #(.ADDR_W(32), .LINE_W(128)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .bus            (bus.slave),
      .busy_o         (busy)
`ifdef ARB_PERF_CNT_EN
      ,
      .conflict_cnt_o (conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   localparam logic [127:0] DBEEF = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
   localparam logic [127:0] A5S   = {16{8'hA5}};

   initial begin
      rst_n               = 1'b0;
      bus.i_req_valid_i   = 1'b0;
      bus.i_req_rw_i      = 1'b0;
      bus.i_req_addr_i    = '0;
      bus.i_req_data_i    = '0;
      bus.d_req_valid_i   = 1'b0;
      bus.d_req_rw_i      = 1'b0;
      bus.d_req_addr_i    = '0;
      bus.d_req_data_i    = '0;
      bus.mem_res_ready_i = 1'b0;
      bus.mem_res_data_i  = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_valid", 128'(bus.mem_req_valid_o), 128'd0);
      chk("rst_busy",      128'(busy),                128'd0);
      chk("rst_mem_addr",  128'(bus.mem_req_addr_o),  128'd0);
      chk("rst_mem_data",  bus.mem_req_data_o,        128'd0);
      rst_n = 1'b1;

      // Single I read
      bus.i_req_valid_i = 1'b1;
      bus.i_req_rw_i    = 1'b0;
      bus.i_req_addr_i  = 32'h0000_1040;
      tick();
      chk("t1_mem_valid", 128'(bus.mem_req_valid_o), 128'd1);
      chk("t1_mem_addr",  128'(bus.mem_req_addr_o),  128'h1040);
      chk("t1_mem_rw",    128'(bus.mem_req_rw_o),    128'd0);
      chk("t1_busy",      128'(busy),                128'd1);
      bus.mem_res_data_i = DBEEF;
      repeat (3) tick();
      chk("t1_hold_valid",  128'(bus.mem_req_valid_o), 128'd1);
      chk("t1_noready_dat", bus.i_res_data_o,          128'd0);
      chk("t1_noready_rdy", 128'(bus.i_res_ready_o),   128'd0);
      bus.mem_res_ready_i = 1'b1;
      #1;
      chk("t1_i_ready", 128'(bus.i_res_ready_o), 128'd1);
      chk("t1_i_data",  bus.i_res_data_o,        DBEEF);
      chk("t1_d_ready", 128'(bus.d_res_ready_o), 128'd0);
      chk("t1_d_data",  bus.d_res_data_o,        128'd0);
      tick();
      bus.mem_res_ready_i = 1'b0;
      bus.i_req_valid_i   = 1'b0;
      chk("t1_rel_valid", 128'(bus.mem_req_valid_o), 128'd0);
      chk("t1_rel_busy",  128'(busy),                128'd1);
      tick();
      chk("t1_idle_busy", 128'(busy), 128'd0);

      // Simultaneous requests right after reset: I first, then D
      do_reset();
      bus.i_req_valid_i = 1'b1;
      bus.i_req_addr_i  = 32'h100;
      bus.d_req_valid_i = 1'b1;
      bus.d_req_addr_i  = 32'h200;
      bus.d_req_rw_i    = 1'b0;
      tick();
      chk("t2_first_addr", 128'(bus.mem_req_addr_o), 128'h100);
      bus.mem_res_ready_i = 1'b1;
      bus.mem_res_data_i  = 128'h1111;
      #1;
      chk("t2_i_ready", 128'(bus.i_res_ready_o), 128'd1);
      chk("t2_d_quiet", 128'(bus.d_res_ready_o), 128'd0);
      tick();
      bus.mem_res_ready_i = 1'b0;
      bus.i_req_valid_i   = 1'b0;
      chk("t2_rel_valid", 128'(bus.mem_req_valid_o), 128'd0);
      tick();
      chk("t2_idle_valid", 128'(bus.mem_req_valid_o), 128'd0);
      chk("t2_idle_busy",  128'(busy),                128'd0);
      tick();
      chk("t2_second_addr",  128'(bus.mem_req_addr_o),  128'h200);
      chk("t2_second_valid", 128'(bus.mem_req_valid_o), 128'd1);
      bus.mem_res_ready_i = 1'b1;
      bus.mem_res_data_i  = 128'h2222;
      #1;
      chk("t2_d_ready", 128'(bus.d_res_ready_o), 128'd1);
      chk("t2_d_data",  bus.d_res_data_o,        128'h2222);
      chk("t2_i_quiet", 128'(bus.i_res_ready_o), 128'd0);
      chk("t2_i_zero",  bus.i_res_data_o,        128'd0);
      tick();
      bus.mem_res_ready_i = 1'b0;
      bus.d_req_valid_i   = 1'b0;
      tick();

      // Continuous contention: strict I/D alternation
      do_reset();
      bus.i_req_valid_i = 1'b1;
      bus.i_req_addr_i  = 32'hA000;
      bus.d_req_valid_i = 1'b1;
      bus.d_req_addr_i  = 32'hB000;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("t3_addr%0d", k), 128'(bus.mem_req_addr_o),
             (k % 2 == 0) ? 128'hA000 : 128'hB000);
         bus.mem_res_ready_i = 1'b1;
         bus.mem_res_data_i  = 128'(k + 1);
         #1;
         chk($sformatf("t3_i_rdy%0d", k), 128'(bus.i_res_ready_o),
             (k % 2 == 0) ? 128'd1 : 128'd0);
         chk($sformatf("t3_d_rdy%0d", k), 128'(bus.d_res_ready_o),
             (k % 2 == 0) ? 128'd0 : 128'd1);
         tick();
         bus.mem_res_ready_i = 1'b0;
         if (k == 5) begin
            bus.i_req_valid_i = 1'b0;
            bus.d_req_valid_i = 1'b0;
         end
         tick();
      end
`ifdef ARB_PERF_CNT_EN
      chk("t3_conflict_cnt", 128'(conflict_cnt), 128'd6);
`endif
      chk("t3_end_idle", 128'(busy), 128'd0);

      // D write-back, fields held while inputs change mid-transaction
      bus.d_req_valid_i = 1'b1;
      bus.d_req_rw_i    = 1'b1;
      bus.d_req_addr_i  = 32'h3000;
      bus.d_req_data_i  = A5S;
      tick();
      chk("t4_rw",   128'(bus.mem_req_rw_o),   128'd1);
      chk("t4_addr", 128'(bus.mem_req_addr_o), 128'h3000);
      chk("t4_data", bus.mem_req_data_o,       A5S);
      bus.d_req_data_i  = ~A5S;
      bus.d_req_addr_i  = 32'h7777;
      bus.d_req_rw_i    = 1'b0;
      bus.i_req_valid_i = 1'b1;
      bus.i_req_addr_i  = 32'h5000;
      tick();
      chk("t4_hold_data", bus.mem_req_data_o,       A5S);
      chk("t4_hold_addr", 128'(bus.mem_req_addr_o), 128'h3000);
      chk("t4_hold_rw",   128'(bus.mem_req_rw_o),   128'd1);
      bus.mem_res_ready_i = 1'b1;
      bus.mem_res_data_i  = 128'h3333;
      #1;
      chk("t4_d_ready", 128'(bus.d_res_ready_o), 128'd1);
      chk("t4_i_quiet", 128'(bus.i_res_ready_o), 128'd0);
      tick();
      bus.mem_res_ready_i = 1'b0;
      bus.d_req_valid_i   = 1'b0;
      bus.i_req_valid_i   = 1'b0;
      tick();

      // Stray response in IDLE, then reset during BUSY
      bus.mem_res_ready_i = 1'b1;
      #1;
      chk("t5_stray_i", 128'(bus.i_res_ready_o), 128'd0);
      chk("t5_stray_d", 128'(bus.d_res_ready_o), 128'd0);
      tick();
      chk("t5_stray_busy", 128'(busy), 128'd0);
      bus.mem_res_ready_i = 1'b0;
      bus.i_req_valid_i   = 1'b1;
      bus.i_req_addr_i    = 32'h4000;
      tick();
      chk("t5_busy_before", 128'(busy), 128'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", 128'(bus.mem_req_valid_o), 128'd0);
      chk("t5_rst_busy",  128'(busy),                128'd0);
      chk("t5_rst_addr",  128'(bus.mem_req_addr_o),  128'd0);
      bus.mem_res_ready_i = 1'b1;
      #1;
      chk("t5_rst_i_ready", 128'(bus.i_res_ready_o), 128'd0);
      bus.mem_res_ready_i = 1'b0;
      bus.i_req_valid_i   = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("t5_after_idle", 128'(busy), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/l2_req_arbiter.md
Name: l2_req_arbiter

Overview:
- Shares one downstream memory/L2 request port between the I-cache miss path (port I) and the D-cache miss/write-back path (port D).
- Grants one requester at a time and latches its request into a registered downstream request.
- Returns the downstream response (line data and ready pulse) only to the granted owner.
- Sits between the L1 caches' mem_req/mem_data interfaces and the L2 cache.

Parameters:
- ADDR_W, 32, request address width.
- LINE_W, 128, cache line / data width.
- CNT_W, 32, width of the optional performance counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- i_req_valid_i  in  1  I-cache request valid; held high until i_res_ready_o.
- i_req_rw_i  in  1  I-cache request type, 0=read 1=write; I-cache issues reads only but is forwarded unchanged.
- i_req_addr_i  in  ADDR_W  I-cache line address.
- i_req_data_i  in  LINE_W  I-cache write data.
- i_res_data_o  out  LINE_W  line returned to the I-cache.
- i_res_ready_o  out  1  one-cycle completion pulse to the I-cache.
- d_req_valid_i, d_req_rw_i, d_req_addr_i, d_req_data_i  in  1/1/ADDR_W/LINE_W  D-cache request, same rules as the I port.
- d_res_data_o  out  LINE_W  line returned to the D-cache.
- d_res_ready_o  out  1  one-cycle completion pulse to the D-cache.
- mem_req_valid_o  out  1  downstream request valid.
- mem_req_rw_o  out  1  downstream request type.
- mem_req_addr_o  out  ADDR_W  downstream address.
- mem_req_data_o  out  LINE_W  downstream write data.
- mem_res_ready_i  in  1  downstream completion; single-cycle pulse.
- mem_res_data_i  in  LINE_W  downstream read data; valid with mem_res_ready_i.
- busy_o  out  1  high in every state except IDLE.
- conflict_cnt_o  out  CNT_W  present only with ARB_PERF_CNT_EN.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - State IDLE; owner=I; rr_last=D, so I wins the first tie.
  - All outputs 0; all mem_req_* registers 0.
- FSM states: IDLE, BUSY, RELEASE.
- IDLE, no valid requester: stay in IDLE.
- IDLE, at least one valid requester:
  - Select the winner.
  - Latch the winner's rw, addr and data into the mem_req_* registers.
  - Set mem_req_valid_o=1 and go to BUSY.
  - Latency: request valid at edge n gives mem_req_valid_o high after edge n.
- Arbitration:
  - Only one requester valid: that requester wins.
  - Both valid: round-robin; the winner is the port not equal to rr_last.
  - rr_last is updated to the winner at grant.
- BUSY:
  - mem_req_valid_o and the mem_req_* fields are held stable.
  - Requester inputs are ignored; changes to them mid-transaction have no effect.
- BUSY with mem_res_ready_i=1:
  - Drive the owner's res_data_o = mem_res_data_i and res_ready_o=1 combinationally in that same cycle.
  - Clear mem_req_valid_o at the edge and go to RELEASE.
  - The non-owner's res_ready_o stays 0.
  - res_data_o of both ports is 0 whenever that port's res_ready_o is 0.
- RELEASE: exactly one cycle with no grant, so the finished requester can drop valid; then return to IDLE.
- Back-to-back traffic:
  - A requester that still holds valid in IDLE after RELEASE is treated as a new request.
  - Minimum turnaround is 3 cycles per transaction: IDLE, BUSY (at least 1 cycle), RELEASE.
- Stray response: mem_res_ready_i in IDLE or RELEASE is ignored and no res_ready_o is asserted.
- Fairness: with both ports continuously valid, grants strictly alternate I, D, I, D, ...
- Reset mid-BUSY:
  - Immediately returns to IDLE and clears mem_req_valid_o.
  - The in-flight response is dropped; the downstream is reset by the same rst_ni.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - conflict_cnt_o counts IDLE grant cycles in which both i_req_valid_i and d_req_valid_i were high.
  - Increments by 1 per such cycle, saturates at all-ones, resets to 0.
- Undefined: the port and the counter logic are absent.

Decomposition:
- Shared package cache_def holds:
  - the ADDR_W and LINE_W defaults;
  - an arb_state_e enum {IDLE, BUSY, RELEASE};
  - an arb_owner_e enum {OWN_I, OWN_D};
  - an arb_req_t struct {rw, addr, data} used for the latched request.
- One natural sub-module: l2_rr_picker. It is combinational and registers nothing; rr_last, the latch and the update belong to l2_req_arbiter.
  - Inputs: two valids and rr_last.
  - Outputs: grant_valid and the winner.

Test Plan:
- Single I read:
  - Stimulus: i_req addr 0x0000_1040, rw=0; mem_res_ready pulse 4 cycles later with data 0xDEAD..BEEF.
  - Response: mem_req_addr_o=0x1040 one cycle after valid; i_res_ready_o pulses once with that data; d_res_ready_o stays 0.
- Simultaneous requests after reset:
  - Stimulus: I addr 0x100, D addr 0x200, both valid in the same cycle.
  - Response: I is granted first; D is issued on the first IDLE after I's RELEASE, and its response goes only to d_res_*.
- Continuous contention:
  - Stimulus: both ports valid for 6 transactions.
  - Response: grant order I, D, I, D, I, D; with ARB_PERF_CNT_EN, conflict_cnt_o=6.
- D write-back:
  - Stimulus: d_req rw=1, addr 0x3000, data 0xA5 repeated.
  - Response: mem_req_rw_o=1 and mem_req_data_o match; held stable while d_req_data_i toggles during BUSY.
- Stray and mid-op reset:
  - Stimulus: mem_res_ready_i pulse while in IDLE; then rst_ni low during BUSY.
  - Response: no res_ready_o on the stray pulse; all outputs go to 0 asynchronously and the state returns to IDLE.
